// File: rtl/simd_pkg.sv
// Shared types and sizes for the packed SIMD datapath (adder and subtractor).
package simd_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = LANE_W * LANES;
  localparam int unsigned CNT_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } simd_state_t;

  // Operand bundle captured at the accept edge
  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic              sat;
  } simd_op_t;

endpackage

// File: rtl/simd_sub_seq_if.sv
// Valid/ready operand and result bus of the lane-serial SIMD subtractor.
interface simd_sub_seq_if;
  import simd_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] x;
  logic [WORD_W-1:0] y;
  logic              sat;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] diff;
  logic [LANES-1:0]  borrow;

  modport master (
    output in_valid, x, y, sat, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, x, y, sat, out_ready,
    output in_ready, out_valid, diff, borrow
  );

endinterface

// File: rtl/simd_lane_sub.sv
// One-lane unsigned subtractor with optional clamp-to-zero on borrow.
module simd_lane_sub
  import simd_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sat,
  output logic [LANE_W-1:0] d,
  output logic              borrow
);

  logic [LANE_W:0] wide;

  // Extra top bit of the widened difference is the lane borrow
  always_comb begin
    wide   = {1'b0, a} - {1'b0, b};
    borrow = wide[LANE_W];
    d      = (sat && borrow) ? '0 : wide[LANE_W-1:0];
  end

endmodule

// File: rtl/simd_sub_seq.sv
// Lane-serial packed SIMD subtractor: one lane per clock, LSB lane first.
module simd_sub_seq
  import simd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  simd_sub_seq_if.slave bus
);

  simd_state_t       state;
  simd_state_t       state_next;
  simd_op_t          op_q;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] diff_q;
  logic [LANES-1:0]  borrow_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_d;
  logic              lane_borrow;
  logic              accept_c;
  logic              last_lane_c;

  assign accept_c    = bus.in_valid && in_ready_q;
  assign last_lane_c = (cnt == CNT_W'(LANES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept_c)      state_next = S_BUSY;
      S_BUSY:  if (last_lane_c)   state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  // Handshake flags registered from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_next == S_IDLE);
      out_valid_q <= (state_next == S_DONE);
    end
  end

  // Counter-selected lane of the registered operands
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (cnt == CNT_W'(k)) begin
        lane_a = op_q.x[k*LANE_W +: LANE_W];
        lane_b = op_q.y[k*LANE_W +: LANE_W];
      end
    end
  end

  simd_lane_sub u_lane (
    .a      (lane_a),
    .b      (lane_b),
    .sat    (op_q.sat),
    .d      (lane_d),
    .borrow (lane_borrow)
  );

  // Operand capture, lane counter and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= '0;
    end else if (accept_c) begin
      op_q     <= '{x: bus.x, y: bus.y, sat: bus.sat};
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= '0;
    end else if (state == S_BUSY) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (cnt == CNT_W'(k)) begin
          diff_q[k*LANE_W +: LANE_W] <= lane_d;
          borrow_q[k]                <= lane_borrow;
        end
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_simd_sub_seq.sv
// Scoreboard bench for the lane-serial SIMD subtractor.
module tb_simd_sub_seq;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_sub_seq_if bus ();

  simd_sub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   hand_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: independent per-lane unsigned subtraction
  function automatic exp_t model(input logic [31:0] xv, input logic [31:0] yv, input logic s);
    exp_t r;
    r.d = '0;
    r.b = '0;
    for (int k = 0; k < 4; k++) begin
      int xi;
      int yi;
      int di;
      xi = int'((xv >> (8 * k)) & 32'hFF);
      yi = int'((yv >> (8 * k)) & 32'hFF);
      r.b[k] = (xi < yi);
      di = (xi < yi) ? (s ? 0 : xi - yi + 256) : xi - yi;
      r.d[8*k +: 8] = 8'(di);
    end
    return r;
  endfunction

  // Pop and compare on every result handoff
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("diff", bus.diff, mon_e.d);
        check("borrow", 32'(bus.borrow), 32'(mon_e.b));
      end
      hand_cyc = cyc + 1;
    end
  end

  // Present an operation and return at #1 after its accept edge
  task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic s, output int acc);
    int budget;
    budget       = 0;
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.y        = yv;
    bus.sat      = s;
    while (!bus.in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      sb.push_back(model(xv, yv, s));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || bus.out_valid) && budget < 100) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (sb.size() != 0 || bus.out_valid) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a;
    int acc_b;
    int dummy;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.sat       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", bus.diff, 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap, wrap with borrow, saturate
    send(32'h10203040, 32'h01020304, 1'b0, dummy);
    bus.in_valid = 1'b0;
    wait_idle();
    send(32'h00FF0180, 32'h01FE0280, 1'b0, dummy);
    bus.in_valid = 1'b0;
    wait_idle();
    send(32'h00FF0180, 32'h01FE0280, 1'b1, dummy);
    bus.in_valid = 1'b0;
    wait_idle();

    // Latency, backpressure and operand changes during BUSY
    bus.out_ready = 1'b0;
    send(32'h10203040, 32'h01020304, 1'b0, dummy);
    bus.in_valid = 1'b0;
    bus.x   = 32'hFFFFFFFF;
    bus.y   = 32'h12345678;
    bus.sat = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", i), 32'(bus.out_valid), 32'(i == 4));
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_diff", bus.diff, 32'h0F1E2D3C);
      check("hold_borrow", 32'(bus.borrow), 32'd0);
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset after two lanes have been processed
    send(32'h00FF0180, 32'h01FE0280, 1'b0, dummy);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_diff", bus.diff, 32'd0);
    check("midrst_borrow", 32'(bus.borrow), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("midrst_hold_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_hold_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send(32'h10203040, 32'h01020304, 1'b0, dummy);
    bus.in_valid = 1'b0;
    wait_idle();

    // Back-to-back with in_valid held high
    bus.out_ready = 1'b1;
    send(32'h00FF0180, 32'h01FE0280, 1'b1, acc_a);
    send(32'h80402010, 32'h90302011, 1'b0, acc_b);
    check("b2b_accept_after_handoff", 32'(acc_b), 32'(hand_cyc + 1));
    check("b2b_issue_interval", 32'(acc_b - acc_a), 32'd6);
    bus.in_valid = 1'b0;
    wait_idle();

    // Random operations, alternating saturate mode
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'(i % 2), dummy);
      bus.in_valid = 1'b0;
      wait_idle();
    end

    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
